load_store_unit: RTL and testbench
==================================

# load_store_unit

Sequences data-memory accesses between the core's execute stage and the word-addressed data RAM (`ru_ram`, 64 × 32-bit, combinational read, registered write, `busy` handshake). Supports byte, halfword and word loads and stores, with little-endian lane selection and sign/zero extension. Sub-word stores use a read-modify-write sequence. Misaligned and out-of-range accesses raise a fault instead of touching memory.

## Interface
- `MEM_WORDS`, default 64: RAM depth in words. Valid byte addresses are 0 .. MEM_WORDS*4-1.
- `clk`  in  1  clock
- `nRst`  in  1  reset, asynchronous, active-low
- `req`  in  1  access request. Sampled only in IDLE.
- `we`  in  1  1 = store, 0 = load
- `size`  in  2  00 byte, 01 half, 10 word, 11 illegal
- `uns`  in  1  load zero-extends when 1 and sign-extends when 0. Ignored for stores and word loads.
- `addr`  in  32  byte address
- `wdata`  in  32  store data, right-justified
- `rdata`  out  32  extended load result. Valid when `done`=1.
- `done`  out  1  one-cycle completion pulse
- `fault`  out  1  qualifies `done`: access rejected
- `busy`  out  1  high in every state except IDLE
- `ram_we`  out  1  RAM write enable
- `ram_addr`  out  32  word-aligned RAM address, {a[31:2],2'b00}
- `ram_wdata`  out  32  RAM write data
- `ram_rdata`  in  32  RAM read data (combinational from `ram_addr`)
- `ram_busy`  in  1  RAM stall. No RAM transaction completes on an edge where it is 1.

## Operation
- **States:** IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- **IDLE, acceptance:** when `req`=1, register `we`, `size`, `uns`, `addr` and `wdata`. The core need not hold them afterwards.
- **IDLE, fault check:** the access faults if any of the following hold:
  - size=11
  - half with addr[0]=1
  - word with addr[1:0]≠0
  - addr ≥ MEM_WORDS*4

  On a fault, go to RESP with fault=1.
- **IDLE, dispatch:** otherwise go to:
  - LOAD if we=0
  - STORE if we=1 and size=word
  - RMW_RD for a sub-word store
- **LOAD:** drive `ram_addr`. On an edge with `ram_busy`=0, capture the extracted, extended lane into `rdata` and go to RESP.
  - Byte lane = addr[1:0]; half lane = addr[1].
  - Sign-extend from bit 7 (byte) or bit 15 (half) unless `uns`=1.
- **STORE:** `ram_we`=1, `ram_wdata`=wdata. On an edge with `ram_busy`=0 (the write commits on that edge), go to RESP.
- **RMW_RD:** on an edge with `ram_busy`=0, register a merged word: `ram_rdata` with the target lane replaced by wdata[7:0] or wdata[15:0]. Go to RMW_WR.
- **RMW_WR:** `ram_we`=1, `ram_wdata`=merged word. On an edge with `ram_busy`=0, go to RESP.
- **RESP:** `done`=1 for exactly one cycle, then IDLE.
  - `rdata` holds the load result.
  - `rdata`=0 on faults and on stores.
  - `fault` is 1 only for rejected accesses.
- **Outside IDLE:** `req` is ignored. No queuing.
- **Write enable:** `ram_we` is 0 in every state other than STORE and RMW_WR.
- **Fault side effects:** a fault never asserts `ram_we`.

## Timing
- **Reset values:**
  - state=IDLE
  - `done`=0, `fault`=0, `busy`=0, `ram_we`=0
  - `rdata`=0, `ram_addr`=0, `ram_wdata`=0
- **Latency (req edge → done cycle), with no stalls:**
  - fault: 1 cycle
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
- **Stalls:** each cycle of `ram_busy`=1 in LOAD, STORE, RMW_RD or RMW_WR adds one cycle. State and outputs hold during the stall.
- **Back-to-back requests:** the earliest next acceptance is the cycle after `done`, so `done` and acceptance never coincide.
- **Reset mid-operation:** asynchronous return to IDLE.
  - `ram_we` drops immediately.
  - The pending access is discarded with no `done`.
  - An RMW interrupted before the RMW_WR edge leaves memory unchanged.

## Structure
- **Package `lsu_pkg`:**
  - `size_t` enum: BYTE=2'b00, HALF=2'b01, WORD=2'b10
  - `lsu_state_t` enum: the six states
  - constant `SIZE_ILLEGAL`=2'b11
- **Sub-module `lsu_align`:** purely combinational.
  - Load extraction/extension: inputs word, addr[1:0], size, uns.
  - Store lane merge: inputs old word, wdata, addr[1:0], size.
- **Top level:** the FSM, registers and RAM port.

## Test plan
1. RAM word 3 = 0x80FF_7F01, load byte at addr 0x0E, uns=0 → `done` on cycle 2 with `rdata`=0xFFFF_FFFF. Repeat with uns=1 → 0x0000_00FF.
2. Store byte 0xAB to addr 0x0D over word 0x1122_3344 → RAM word 3 = 0x1122_AB44 on cycle 3. Only `ram_we` cycles are in RMW_WR.
3. Load half at addr 0x03 → `done`=1, `fault`=1, `rdata`=0 on cycle 1. `ram_we` never asserted.
4. Store word to addr 0x100 (MEM_WORDS=64) → fault. Store word 0xDEAD_BEEF to 0xFC → word 63 = 0xDEAD_BEEF.
5. Hold `ram_busy`=1 for 3 cycles during a word load → `done` on cycle 5 with correct data. `req` pulsed mid-access is ignored.
6. Deassert `nRst` in RMW_RD → all outputs return to reset values. No `done`. Target word unchanged.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and constants for the load/store unit
// Purpose: access-size encoding, FSM state type and the illegal-size code.
// Ports: none (package).
package lsu_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } size_t;

  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE,
    RMW_RD,
    RMW_WR,
    RESP
  } lsu_state_t;

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - core and RAM port bundle of the load/store unit
// Purpose: groups the execute-stage request/response and the data RAM port.
// Ports:
//   core side : req, we, size, uns, addr, wdata -> LSU; rdata, done, fault, busy <- LSU
//   RAM side  : ram_we, ram_addr, ram_wdata <- LSU; ram_rdata, ram_busy -> LSU
//   master    : the environment (core + RAM); slave : the load/store unit
interface load_store_unit_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        fault;
  logic        busy;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_busy;

  modport master (
    output req, we, size, uns, addr, wdata, ram_rdata, ram_busy,
    input  rdata, done, fault, busy, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    input  req, we, size, uns, addr, wdata, ram_rdata, ram_busy,
    output rdata, done, fault, busy, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - little-endian lane extraction/extension and store lane merge
// Purpose: purely combinational data alignment for loads and sub-word stores.
// Ports:
//   i_word   : RAM word for load extraction
//   i_old    : RAM word to be merged for a sub-word store
//   i_lane   : byte address bits [1:0]
//   i_size   : access size code
//   i_uns    : 1 = zero-extend, 0 = sign-extend
//   i_wdata  : right-justified store data (only the low halfword can be merged)
//   o_load   : extracted, extended load result
//   o_merged : i_old with the target lane replaced
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_old,
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic        i_uns,
  input  logic [15:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_lane)
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      2'd3:    w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    // Halfwords are always 2-byte aligned here, so only lane bit 1 matters.
    w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    o_load = i_word;
    if (i_size == BYTE) begin
      o_load = {{24{~i_uns & w_byte[7]}}, w_byte};
    end else if (i_size == HALF) begin
      o_load = {{16{~i_uns & w_half[15]}}, w_half};
    end
  end

  always_comb begin
    o_merged = i_old;
    if (i_size == BYTE) begin
      case (i_lane)
        2'd1:    o_merged[15:8]  = i_wdata[7:0];
        2'd2:    o_merged[23:16] = i_wdata[7:0];
        2'd3:    o_merged[31:24] = i_wdata[7:0];
        default: o_merged[7:0]   = i_wdata[7:0];
      endcase
    end else if (i_size == HALF) begin
      if (i_lane[1]) o_merged[31:16] = i_wdata;
      else           o_merged[15:0]  = i_wdata;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory access sequencer between execute stage and data RAM
// Purpose: byte/half/word loads and stores with fault checking, read-modify-write
//          for sub-word stores, and a one-cycle done/fault response.
// Ports:
//   clk  : clock
//   nRst : asynchronous active-low reset
//   bus  : load_store_unit_if.slave (core request/response and RAM port)
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 64
) (
  input  logic             clk,
  input  logic             nRst,
  load_store_unit_if.slave bus
);

  // One bit wider than the address so that a full 4 GiB RAM still compares correctly.
  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

  lsu_state_t  r_state;
  lsu_state_t  w_next;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [31:0] r_merged;
  logic        r_fault;
  logic        w_reject;
  logic        w_ram_we;
  logic [31:0] w_ram_wdata;
  logic [31:0] w_load;
  logic [31:0] w_merged;

  // Evaluated on the live request inputs; only meaningful when accepting in IDLE.
  assign w_reject = (bus.size == SIZE_ILLEGAL)
                  | ((bus.size == HALF) & bus.addr[0])
                  | ((bus.size == WORD) & (bus.addr[1:0] != 2'b00))
                  | ({1'b0, bus.addr} >= ADDR_LIMIT);

  lsu_align u_align (
    .i_word   (bus.ram_rdata),
    .i_old    (bus.ram_rdata),
    .i_lane   (r_addr[1:0]),
    .i_size   (r_size),
    .i_uns    (r_uns),
    .i_wdata  (r_wdata[15:0]),
    .o_load   (w_load),
    .o_merged (w_merged)
  );

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // The kind of access (load / word store / sub-word store) is carried by the
  // state itself, so the store flag is consumed at dispatch and not kept.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.req) begin
          if (w_reject)              w_next = RESP;
          else if (!bus.we)          w_next = LOAD;
          else if (bus.size == WORD) w_next = STORE;
          else                       w_next = RMW_RD;
        end
      end
      LOAD, STORE: if (!bus.ram_busy) w_next = RESP;
      RMW_RD:      if (!bus.ram_busy) w_next = RMW_WR;
      RMW_WR:      if (!bus.ram_busy) w_next = RESP;
      RESP:        w_next = IDLE;
      default:     w_next = IDLE;
    endcase
  end

  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_wdata = '0;
    case (r_state)
      STORE: begin
        w_ram_we    = 1'b1;
        w_ram_wdata = r_wdata;
      end
      RMW_WR: begin
        w_ram_we    = 1'b1;
        w_ram_wdata = r_merged;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_size   <= '0;
      r_uns    <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_merged <= '0;
      r_fault  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req) begin
            r_size  <= bus.size;
            r_uns   <= bus.uns;
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
            r_fault <= w_reject;
            // Cleared here so faults and stores answer with zero data.
            r_rdata <= '0;
          end
        end
        LOAD:    if (!bus.ram_busy) r_rdata  <= w_load;
        RMW_RD:  if (!bus.ram_busy) r_merged <= w_merged;
        default: ;
      endcase
    end
  end

  assign bus.done      = (r_state == RESP);
  assign bus.fault     = (r_state == RESP) & r_fault;
  assign bus.busy      = (r_state != IDLE);
  assign bus.rdata     = r_rdata;
  assign bus.ram_we    = w_ram_we;
  assign bus.ram_wdata = w_ram_wdata;
  assign bus.ram_addr  = {r_addr[31:2], 2'b00};

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;

  localparam int MEM_WORDS = 64;

  logic clk  = 1'b0;
  logic nRst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  load_store_unit_if bus ();

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Data RAM: combinational read, write on an edge with ram_busy=0.
  // The bk_* port lets the bench preload words.
  logic [31:0] ram_mem   [MEM_WORDS];
  logic [31:0] model_mem [MEM_WORDS];
  logic        bk_we   = 1'b0;
  logic [5:0]  bk_idx  = '0;
  logic [31:0] bk_data = '0;

  assign bus.ram_rdata = ram_mem[bus.ram_addr[7:2]];

  always @(posedge clk) begin
    if (bk_we) ram_mem[bk_idx] <= bk_data;
    else if (bus.ram_we && !bus.ram_busy) ram_mem[bus.ram_addr[7:2]] <= bus.ram_wdata;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic bit model_fault(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a % 2 != 0) ||
           (sz == 2'b10 && a % 4 != 0) || (a >= 32'(MEM_WORDS * 4));
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic u, input logic [31:0] a);
    int sh;
    longint v;
    if (sz == 2'b10) return w;
    sh = int'(a % 4) * 8;
    if (sz == 2'b00) begin
      v = longint'((w >> sh) & 32'hFF);
      if (!u && v >= 128) v = v - 256;
    end else begin
      v = longint'((w >> sh) & 32'hFFFF);
      if (!u && v >= 32768) v = v - 65536;
    end
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [31:0] a, input logic [31:0] wd);
    int sh;
    logic [31:0] mask;
    if (sz == 2'b10) return wd;
    sh   = int'(a % 4) * 8;
    mask = (sz == 2'b00) ? 32'hFF : 32'hFFFF;
    return (w & ~(mask << sh)) | ((wd & mask) << sh);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preset(input int idx, input logic [31:0] val);
    bk_we   = 1'b1;
    bk_idx  = idx[5:0];
    bk_data = val;
    tick();
    bk_we = 1'b0;
    model_mem[idx] = val;
  endtask

  // Issues one request and waits for done. lat counts edges from the accepting
  // edge to the done cycle; ram_busy is held for the first 'stall' cycles after
  // acceptance. With pulse set, a dangerous word store request is pulsed mid-access.
  task automatic run_access(input logic w, input logic [1:0] sz, input logic u,
                            input logic [31:0] a, input logic [31:0] wd,
                            input int stall, input bit pulse,
                            output logic [31:0] rd, output logic flt,
                            output int lat, output int wcnt);
    bus.req = 1'b1; bus.we = w; bus.size = sz; bus.uns = u;
    bus.addr = a; bus.wdata = wd; bus.ram_busy = 1'b0;
    tick();
    bus.req   = 1'b0;
    bus.we    = 1'($urandom);
    bus.size  = 2'($urandom);
    bus.uns   = 1'($urandom);
    bus.addr  = $urandom;
    bus.wdata = $urandom;
    lat  = 1;
    wcnt = 0;
    while (lat < 60 && !bus.done) begin
      if (bus.ram_we) wcnt++;
      bus.ram_busy = (lat <= stall);
      if (pulse && lat == 2) begin
        bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b10;
        bus.addr = {a[31:2], 2'b00}; bus.wdata = 32'h5A5A_5A5A;
      end else begin
        bus.req = 1'b0;
      end
      tick();
      lat++;
    end
    rd  = bus.rdata;
    flt = bus.fault;
    bus.ram_busy = 1'b0;
    bus.req = 1'b0;
  endtask

  task automatic test_reset();
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b10; bus.uns = 1'b0;
    bus.addr = 32'h10; bus.wdata = 32'hFFFF_FFFF; bus.ram_busy = 1'b0;
    #1 nRst = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bus.done, bus.fault, bus.busy, bus.ram_we} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: done/fault/busy/ram_we got %b expected 0000",
               {bus.done, bus.fault, bus.busy, bus.ram_we});
    end
    checks++;
    if ({bus.rdata, bus.ram_addr, bus.ram_wdata} !== 96'd0) begin
      errors++;
      $display("FAIL reset_data: rdata %h ram_addr %h ram_wdata %h expected all zero",
               bus.rdata, bus.ram_addr, bus.ram_wdata);
    end
    bus.req = 1'b0;
    nRst = 1'b1;
    for (int i = 0; i < MEM_WORDS; i++) preset(i, $urandom);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy %b done %b expected 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_load_ext();
    logic [31:0] rd;
    logic flt;
    int lat, wc;
    preset(3, 32'h80FF_7F01);
    run_access(1'b0, 2'b00, 1'b0, 32'h0E, $urandom, 0, 1'b0, rd, flt, lat, wc);
    checks++;
    if (lat != 2 || rd !== 32'hFFFF_FFFF || flt !== 1'b0) begin
      errors++;
      $display("FAIL load_byte_signed: lat %0d rdata %h fault %b expected 2 ffffffff 0", lat, rd, flt);
    end
    tick();
    run_access(1'b0, 2'b00, 1'b1, 32'h0E, $urandom, 0, 1'b0, rd, flt, lat, wc);
    checks++;
    if (lat != 2 || rd !== 32'h0000_00FF || flt !== 1'b0) begin
      errors++;
      $display("FAIL load_byte_unsigned: lat %0d rdata %h fault %b expected 2 000000ff 0", lat, rd, flt);
    end
    tick();
    run_access(1'b0, 2'b01, 1'b0, 32'h0C, $urandom, 0, 1'b0, rd, flt, lat, wc);
    checks++;
    if (rd !== 32'h0000_7F01) begin
      errors++;
      $display("FAIL load_half_low: rdata %h expected 00007f01", rd);
    end
    tick();
    run_access(1'b0, 2'b01, 1'b0, 32'h0E, $urandom, 0, 1'b0, rd, flt, lat, wc);
    checks++;
    if (rd !== 32'hFFFF_80FF) begin
      errors++;
      $display("FAIL load_half_high: rdata %h expected ffff80ff", rd);
    end
    tick();
  endtask

  task automatic test_rmw_store();
    logic [31:0] rd;
    logic flt;
    int lat, wc;
    preset(3, 32'h1122_3344);
    run_access(1'b1, 2'b00, 1'b0, 32'h0D, 32'hFFFF_FFAB, 0, 1'b0, rd, flt, lat, wc);
    checks++;
    if (lat != 3 || wc != 1 || flt !== 1'b0 || rd !== 32'd0) begin
      errors++;
      $display("FAIL rmw_byte_resp: lat %0d we_cycles %0d fault %b rdata %h expected 3 1 0 0", lat, wc, flt, rd);
    end
    checks++;
    if (ram_mem[3] !== 32'h1122_AB44) begin
      errors++;
      $display("FAIL rmw_byte_mem: word3 %h expected 1122ab44", ram_mem[3]);
    end
    model_mem[3] = 32'h1122_AB44;
    tick();
  endtask

  task automatic test_faults();
    logic [31:0] rd;
    logic flt;
    int lat, wc;
    run_access(1'b0, 2'b01, 1'b0, 32'h03, $urandom, 0, 1'b0, rd, flt, lat, wc);
    checks++;
    if (lat != 1 || flt !== 1'b1 || rd !== 32'd0 || wc != 0) begin
      errors++;
      $display("FAIL misaligned_half: lat %0d fault %b rdata %h we_cycles %0d expected 1 1 0 0", lat, flt, rd, wc);
    end
    tick();
    run_access(1'b1, 2'b10, 1'b0, 32'h100, 32'h1234_5678, 0, 1'b0, rd, flt, lat, wc);
    checks++;
    if (lat != 1 || flt !== 1'b1 || wc != 0 || ram_mem[0] !== model_mem[0]) begin
      errors++;
      $display("FAIL out_of_range: lat %0d fault %b we_cycles %0d word0 %h expected 1 1 0 %h",
               lat, flt, wc, ram_mem[0], model_mem[0]);
    end
    tick();
    run_access(1'b1, 2'b10, 1'b0, 32'hFC, 32'hDEAD_BEEF, 0, 1'b0, rd, flt, lat, wc);
    checks++;
    if (lat != 2 || flt !== 1'b0 || ram_mem[63] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL top_word_store: lat %0d fault %b word63 %h expected 2 0 deadbeef", lat, flt, ram_mem[63]);
    end
    model_mem[63] = 32'hDEAD_BEEF;
    tick();
    run_access(1'b0, 2'b11, 1'b1, 32'h10, $urandom, 0, 1'b0, rd, flt, lat, wc);
    checks++;
    if (lat != 1 || flt !== 1'b1 || rd !== 32'd0) begin
      errors++;
      $display("FAIL illegal_size: lat %0d fault %b rdata %h expected 1 1 0", lat, flt, rd);
    end
    tick();
  endtask

  task automatic test_stall();
    logic [31:0] rd;
    logic flt;
    int lat, wc;
    run_access(1'b0, 2'b10, 1'b0, 32'h20, $urandom, 3, 1'b1, rd, flt, lat, wc);
    checks++;
    if (lat != 5 || rd !== model_mem[8] || flt !== 1'b0) begin
      errors++;
      $display("FAIL stalled_load: lat %0d rdata %h fault %b expected 5 %h 0", lat, rd, flt, model_mem[8]);
    end
    tick();
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || ram_mem[8] !== model_mem[8]) begin
      errors++;
      $display("FAIL pulsed_req_ignored: done %b busy %b word8 %h expected 0 0 %h",
               bus.done, bus.busy, ram_mem[8], model_mem[8]);
    end
  endtask

  task automatic test_reset_mid();
    bit seen_done;
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b00; bus.uns = 1'b0;
    bus.addr = 32'h15; bus.wdata = 32'hCC; bus.ram_busy = 1'b1;
    tick();
    bus.req = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.ram_we !== 1'b0) begin
      errors++;
      $display("FAIL rmw_rd_entered: busy %b ram_we %b expected 1 0", bus.busy, bus.ram_we);
    end
    tick();
    #2 nRst = 1'b0;
    #1;
    checks++;
    if ({bus.done, bus.fault, bus.busy, bus.ram_we} !== 4'b0000 ||
        {bus.rdata, bus.ram_addr, bus.ram_wdata} !== 96'd0) begin
      errors++;
      $display("FAIL async_reset_outputs: flags %b rdata %h ram_addr %h ram_wdata %h expected all zero",
               {bus.done, bus.fault, bus.busy, bus.ram_we}, bus.rdata, bus.ram_addr, bus.ram_wdata);
    end
    bus.ram_busy = 1'b0;
    seen_done = 1'b0;
    repeat (2) begin
      tick();
      if (bus.done) seen_done = 1'b1;
    end
    nRst = 1'b1;
    repeat (2) begin
      tick();
      if (bus.done) seen_done = 1'b1;
    end
    checks++;
    if (seen_done || bus.busy !== 1'b0 || ram_mem[5] !== model_mem[5]) begin
      errors++;
      $display("FAIL reset_discards_rmw: done_seen %b busy %b word5 %h expected 0 0 %h",
               seen_done, bus.busy, ram_mem[5], model_mem[5]);
    end
  endtask

  task automatic test_back_to_back();
    bit exp_done, exp_busy;
    bus.req = 1'b1; bus.we = 1'b0; bus.size = 2'b10; bus.uns = 1'b0;
    bus.addr = 32'h28; bus.wdata = '0; bus.ram_busy = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      tick();
      exp_done = (j == 2 || j == 5);
      exp_busy = (j != 3);
      checks++;
      if (bus.done !== exp_done || bus.busy !== exp_busy ||
          (exp_done && bus.rdata !== model_mem[10])) begin
        errors++;
        $display("FAIL back_to_back_c%0d: done %b busy %b rdata %h expected %b %b %h",
                 j, bus.done, bus.busy, bus.rdata, exp_done, exp_busy, model_mem[10]);
      end
    end
    bus.req = 1'b0;
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_idle: done %b busy %b expected 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, a, wd, exp_rd;
    logic flt, w, u, exp_f;
    logic [1:0] sz;
    int lat, wc, k, exp_lat, exp_wc;
    for (int n = 0; n < 150; n++) begin
      w  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      u  = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, MEM_WORDS * 4 + 15));
      if (sz != 2'b11 && $urandom_range(0, 3) != 0) a = a & ~32'((1 << sz) - 1);
      wd = $urandom;
      k  = $urandom_range(0, 2);
      exp_f  = model_fault(sz, a);
      exp_rd = '0;
      if (exp_f) begin
        exp_lat = 1; exp_wc = 0;
      end else if (!w) begin
        exp_rd = model_load(model_mem[a[7:2]], sz, u, a);
        exp_lat = 2 + k; exp_wc = 0;
      end else if (sz == 2'b10) begin
        model_mem[a[7:2]] = wd;
        exp_lat = 2 + k; exp_wc = 1 + k;
      end else begin
        model_mem[a[7:2]] = model_store(model_mem[a[7:2]], sz, a, wd);
        exp_lat = 3 + k; exp_wc = 1;
      end
      run_access(w, sz, u, a, wd, k, 1'b0, rd, flt, lat, wc);
      checks++;
      if (flt !== exp_f || rd !== exp_rd || lat != exp_lat || wc != exp_wc) begin
        errors++;
        $display("FAIL random_%0d we%b sz%0d a%h: fault %b rdata %h lat %0d we_cycles %0d expected %b %h %0d %0d",
                 n, w, sz, a, flt, rd, lat, wc, exp_f, exp_rd, exp_lat, exp_wc);
      end
      tick();
      checks++;
      if (bus.done !== 1'b0) begin
        errors++;
        $display("FAIL done_single_cycle_%0d: done %b expected 0", n, bus.done);
      end
    end
    for (int i = 0; i < MEM_WORDS; i++) begin
      checks++;
      if (ram_mem[i] !== model_mem[i]) begin
        errors++;
        $display("FAIL mem_word_%0d: got %h expected %h", i, ram_mem[i], model_mem[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_ext();
    test_rmw_store();
    test_faults();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
